asrv32_lsu: RTL and testbench
=============================

// Module: asrv32_lsu
// PURPOSE
// Load/store unit for the unpipelined ASRV32 core; the memory-access stage fed by the control FSM.
// - Started by the FSM's memory-access enable; takes the ALU-computed address and rs2 data.
// - Runs one data-memory transaction over a req/ack bus and holds the FSM via o_stall until complete.
// - Returns sign- or zero-extended load data for writeback; flags misaligned and bus-error accesses.
// PARAMETERS
// TIMEOUT_CYCLES  16  max ACCESS cycles without ack before bus error; 0 disables timeout
// PORTS
// i_clk             in   1   clock
// i_rst_n           in   1   async active-low reset
// i_start           in   1   memory-access stage enable from FSM (level)
// i_load            in   1   decoded LOAD opcode
// i_store           in   1   decoded STORE opcode
// i_funct3          in   3   access size/sign (LB0 LH1 LW2 LBU4 LHU5; SB0 SH1 SW2)
// i_addr            in   32  effective byte address (ALU result)
// i_rs2_data        in   32  store data
// o_stall           out  1   hold FSM in memory-access stage
// o_done            out  1   1-cycle pulse: access finished (or skipped)
// o_load_data       out  32  extended load result, valid from o_done until next start
// o_misaligned      out  1   1-cycle pulse with o_done: misaligned or illegal funct3
// o_bus_err         out  1   1-cycle pulse with o_done: i_dmem_err or timeout
// o_dmem_req        out  1   bus request, held until ack
// o_dmem_we         out  1   1=write
// o_dmem_addr       out  32  word address {i_addr[31:2],2'b00}
// o_dmem_wdata      out  32  lane-replicated store data
// o_dmem_wstrb      out  4   byte enables (0 on reads)
// i_dmem_ack        in   1   transaction complete; may assert in the first req cycle
// i_dmem_rdata      in   32  read word, valid with ack
// i_dmem_err        in   1   bus error, valid with ack
// BEHAVIOUR
// - Reset: state IDLE; all outputs 0, o_load_data 0. Async reset mid-transaction drops o_dmem_req immediately.
// - States: IDLE -> ACCESS -> DONE -> IDLE; IDLE -> DONE directly for skipped/faulting starts.
// - IDLE: i_start sampled only here. Start with load|store, legal funct3, aligned -> latch addr/data/size; ACCESS next cycle.
// - Start with neither load nor store -> DONE, no bus cycle, o_load_data unchanged.
// - Misalignment: H with addr[0]=1; W with addr[1:0]!=0. Illegal funct3: load 3/6/7, store >=3.
//   Either -> DONE with o_misaligned=1, no bus cycle.
// - ACCESS: registered o_dmem_* valid; req held stable until ack sampled high. On ack -> DONE; capture rdata; bus_err=i_dmem_err.
// - Timeout: counter clears on ACCESS entry; at TIMEOUT_CYCLES cycles without ack, drop req -> DONE with o_bus_err=1.
// - DONE: o_done=1 for exactly one cycle -> IDLE. Start held high through DONE must not re-trigger: re-arm only after i_start low.
// - o_stall = (IDLE & i_start & (i_load|i_store) & !armed-block) | ACCESS. Combinational; low in DONE.
// - Latency: start @N, req @N+1, ack @A>=N+1, o_done @A+1. Skipped starts: o_done @N+1.
// - Store lanes: SB wdata={4{rs2[7:0]}}, wstrb=4'b0001<<addr[1:0]; SH wdata={2{rs2[15:0]}}, wstrb=addr[1]?1100:0011; SW 1111.
// - Load extract from captured rdata by addr[1:0]; LB/LH sign-extend, LBU/LHU zero-extend, LW pass-through.
// - Ack/err outside ACCESS ignored. i_start while not IDLE ignored.
// STRUCTURE
// - funct3 size encodings and LSU state encodings belong in asrv32_header.vh.
// - Sub-module asrv32_lsu_align: combinational store lane steering, wstrb generation, load extraction and extension,
//   misalignment/illegal check. Top holds FSM, latches, timeout counter.
// TESTING
// - SW addr 0x104 data 0xDEADBEEF, ack after 2 cycles -> wstrb 1111, addr 0x104, o_done @ack+1, stall low in DONE.
// - LB addr 0x203 rdata 0x80112233, ack same cycle as req -> o_load_data 0xFFFFFF80; LBU -> 0x00000080.
// - SH addr 0x302 rs2 0x0000ABCD -> wdata 0xABCDABCD, wstrb 1100; LH addr 0x301 -> no req, o_misaligned + o_done @N+1.
// - Load, no ack for TIMEOUT_CYCLES=16 -> req drops, o_bus_err + o_done; ack with i_dmem_err=1 -> o_bus_err.
// - Assert i_rst_n low during ACCESS -> req 0 same cycle; state IDLE; later ack ignored; next start works.
// - i_start held high 5 cycles with non-mem opcode -> single o_done pulse; no further done until start cycles low.

Source files
------------

// File: rtl/asrv32_lsu_pkg.sv
// Shared encodings for the ASRV32 load/store unit: funct3 access sizes, FSM states, latched access metadata.
// Pure declarations, no timing behaviour.
package asrv32_lsu_pkg;

    localparam logic [2:0] F3_B  = 3'd0;
    localparam logic [2:0] F3_H  = 3'd1;
    localparam logic [2:0] F3_W  = 3'd2;
    localparam logic [2:0] F3_BU = 3'd4;
    localparam logic [2:0] F3_HU = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } lsu_state_t;

    typedef struct packed {
        logic       is_load;
        logic [2:0] funct3;
        logic [1:0] addr_lo;
    } lsu_meta_t;

    // Loads accept B/H/W and the unsigned B/H forms; stores only B/H/W.
    function automatic logic f3_legal(input logic is_load, input logic [2:0] f3);
        if (is_load) begin
            return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
                   (f3 == F3_BU) || (f3 == F3_HU);
        end
        return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
    endfunction

endpackage

// File: rtl/asrv32_lsu_align.sv
// Combinational lane logic: store data replication and byte strobes, load byte/half extraction with extension,
// misalignment and illegal-funct3 detection. Zero latency, no flow control.
module asrv32_lsu_align
    import asrv32_lsu_pkg::*;
(
    input  logic        i_load,
    input  logic        i_store,
    input  logic [2:0]  i_funct3,
    input  logic [1:0]  i_addr_lo,
    input  logic [31:0] i_rs2_data,
    input  logic [31:0] i_rdata,
    output logic        o_fault,
    output logic [31:0] o_wdata,
    output logic [3:0]  o_wstrb,
    output logic [31:0] o_load_data
);

    logic        w_misaligned;
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        case (i_funct3[1:0])
            2'd1:    w_misaligned = i_addr_lo[0];
            2'd2:    w_misaligned = |i_addr_lo;
            default: w_misaligned = 1'b0;
        endcase
    end

    assign o_fault = (i_load | i_store) & (w_misaligned | !f3_legal(i_load, i_funct3));

    always_comb begin
        o_wdata = i_rs2_data;
        o_wstrb = 4'b0000;
        if (i_store && !i_load) begin
            case (i_funct3)
                F3_B: begin
                    o_wdata = {4{i_rs2_data[7:0]}};
                    o_wstrb = 4'b0001 << i_addr_lo;
                end
                F3_H: begin
                    o_wdata = {2{i_rs2_data[15:0]}};
                    o_wstrb = i_addr_lo[1] ? 4'b1100 : 4'b0011;
                end
                F3_W:    o_wstrb = 4'b1111;
                default: o_wstrb = 4'b0000;
            endcase
        end
    end

    always_comb begin
        case (i_addr_lo)
            2'd0:    w_byte = i_rdata[7:0];
            2'd1:    w_byte = i_rdata[15:8];
            2'd2:    w_byte = i_rdata[23:16];
            default: w_byte = i_rdata[31:24];
        endcase
        w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];
    end

    always_comb begin
        case (i_funct3)
            F3_B:    o_load_data = {{24{w_byte[7]}}, w_byte};
            F3_BU:   o_load_data = {24'd0, w_byte};
            F3_H:    o_load_data = {{16{w_half[15]}}, w_half};
            F3_HU:   o_load_data = {16'd0, w_half};
            F3_W:    o_load_data = i_rdata;
            default: o_load_data = 32'd0;
        endcase
    end

endmodule

// File: rtl/asrv32_lsu.sv
// Load/store unit: one data-memory transaction per start, stalling the FSM until ack, timeout or fault.
// Latency: req one cycle after start, o_done one cycle after ack; skipped/faulting starts finish the next cycle.
module asrv32_lsu
    import asrv32_lsu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_start,
    input  logic        i_load,
    input  logic        i_store,
    input  logic [2:0]  i_funct3,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_rs2_data,
    output logic        o_stall,
    output logic        o_done,
    output logic [31:0] o_load_data,
    output logic        o_misaligned,
    output logic        o_bus_err,
    output logic        o_dmem_req,
    output logic        o_dmem_we,
    output logic [31:0] o_dmem_addr,
    output logic [31:0] o_dmem_wdata,
    output logic [3:0]  o_dmem_wstrb,
    input  logic        i_dmem_ack,
    input  logic [31:0] i_dmem_rdata,
    input  logic        i_dmem_err
);

    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    lsu_state_t  r_state;
    lsu_meta_t   r_meta;
    logic        r_armed;
    logic [TW-1:0] r_tmo;

    logic        w_idle;
    logic        w_mem;
    logic        w_accept;
    logic        w_sel_load;
    logic        w_sel_store;
    logic [2:0]  w_f3;
    logic [1:0]  w_addr_lo;
    logic        w_fault;
    logic [31:0] w_wdata;
    logic [3:0]  w_wstrb;
    logic [31:0] w_load_data;

    assign w_idle   = (r_state == ST_IDLE);
    assign w_mem    = i_load | i_store;
    assign w_accept = w_idle & i_start & r_armed;
    assign o_stall  = (w_accept & w_mem) | (r_state == ST_ACCESS);

    // The aligner sees live decode while idle and the latched access afterwards, when only extraction matters.
    assign w_sel_load  = w_idle ? i_load : r_meta.is_load;
    assign w_sel_store = w_idle & i_store;
    assign w_f3        = w_idle ? i_funct3 : r_meta.funct3;
    assign w_addr_lo   = w_idle ? i_addr[1:0] : r_meta.addr_lo;

    asrv32_lsu_align u_align (
        .i_load      (w_sel_load),
        .i_store     (w_sel_store),
        .i_funct3    (w_f3),
        .i_addr_lo   (w_addr_lo),
        .i_rs2_data  (i_rs2_data),
        .i_rdata     (i_dmem_rdata),
        .o_fault     (w_fault),
        .o_wdata     (w_wdata),
        .o_wstrb     (w_wstrb),
        .o_load_data (w_load_data)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= ST_IDLE;
            r_meta       <= '0;
            r_armed      <= 1'b1;
            r_tmo        <= '0;
            o_done       <= 1'b0;
            o_misaligned <= 1'b0;
            o_bus_err    <= 1'b0;
            o_load_data  <= 32'd0;
            o_dmem_req   <= 1'b0;
            o_dmem_we    <= 1'b0;
            o_dmem_addr  <= 32'd0;
            o_dmem_wdata <= 32'd0;
            o_dmem_wstrb <= 4'd0;
        end else begin
            o_done       <= 1'b0;
            o_misaligned <= 1'b0;
            o_bus_err    <= 1'b0;
            // A level start that stays high across DONE must not launch a second access.
            if (!i_start) begin
                r_armed <= 1'b1;
            end
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_armed <= 1'b0;
                        if (w_mem && !w_fault) begin
                            r_state      <= ST_ACCESS;
                            r_tmo        <= '0;
                            r_meta       <= '{is_load: i_load, funct3: i_funct3, addr_lo: i_addr[1:0]};
                            o_dmem_req   <= 1'b1;
                            o_dmem_we    <= i_store & ~i_load;
                            o_dmem_addr  <= {i_addr[31:2], 2'b00};
                            o_dmem_wdata <= w_wdata;
                            o_dmem_wstrb <= w_wstrb;
                        end else begin
                            r_state      <= ST_DONE;
                            o_done       <= 1'b1;
                            o_misaligned <= w_mem;
                        end
                    end
                end
                ST_ACCESS: begin
                    if (i_dmem_ack) begin
                        r_state    <= ST_DONE;
                        o_dmem_req <= 1'b0;
                        o_done     <= 1'b1;
                        o_bus_err  <= i_dmem_err;
                        if (r_meta.is_load) begin
                            o_load_data <= w_load_data;
                        end
                    end else if (TIMEOUT_CYCLES != 0 && r_tmo == TMO_LAST) begin
                        r_state    <= ST_DONE;
                        o_dmem_req <= 1'b0;
                        o_done     <= 1'b1;
                        o_bus_err  <= 1'b1;
                    end else begin
                        r_tmo <= r_tmo + 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_asrv32_lsu.sv
// Bench for asrv32_lsu: fixed vector table, hand-written reset/held-start sequences, randomized accesses vs. model.
module tb_asrv32_lsu;

    localparam int TMO = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_start, i_load, i_store;
    logic [2:0]  i_funct3;
    logic [31:0] i_addr, i_rs2_data;
    logic        o_stall, o_done, o_misaligned, o_bus_err;
    logic [31:0] o_load_data;
    logic        o_dmem_req, o_dmem_we;
    logic [31:0] o_dmem_addr, o_dmem_wdata;
    logic [3:0]  o_dmem_wstrb;
    logic        i_dmem_ack, i_dmem_err;
    logic [31:0] i_dmem_rdata;

    always #5 clk = ~clk;

    asrv32_lsu #(.TIMEOUT_CYCLES(TMO)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(i_start), .i_load(i_load), .i_store(i_store),
        .i_funct3(i_funct3), .i_addr(i_addr), .i_rs2_data(i_rs2_data),
        .o_stall(o_stall), .o_done(o_done), .o_load_data(o_load_data),
        .o_misaligned(o_misaligned), .o_bus_err(o_bus_err),
        .o_dmem_req(o_dmem_req), .o_dmem_we(o_dmem_we), .o_dmem_addr(o_dmem_addr),
        .o_dmem_wdata(o_dmem_wdata), .o_dmem_wstrb(o_dmem_wstrb),
        .i_dmem_ack(i_dmem_ack), .i_dmem_rdata(i_dmem_rdata), .i_dmem_err(i_dmem_err)
    );

    typedef struct {
        logic        ld, st;
        logic [2:0]  f3;
        logic [31:0] addr, rs2;
        int          dly;          // cycles after req before ack; >= TMO means never ack
        logic [31:0] rdata;
        logic        err;
        logic        e_fault;
        logic [3:0]  e_wstrb;
        logic [31:0] e_wdata;
        logic        chk_ld;
        logic [31:0] e_ld;
        logic        e_berr;
    } vec_t;

    vec_t vecs[$];
    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic add_vec(input logic ld, input logic st, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] rs2, input int dly, input logic [31:0] rdata, input logic err,
                           input logic e_fault, input logic [3:0] e_wstrb, input logic [31:0] e_wdata,
                           input logic chk_ld, input logic [31:0] e_ld, input logic e_berr);
        vec_t v;
        v.ld = ld; v.st = st; v.f3 = f3; v.addr = addr; v.rs2 = rs2; v.dly = dly;
        v.rdata = rdata; v.err = err; v.e_fault = e_fault; v.e_wstrb = e_wstrb;
        v.e_wdata = e_wdata; v.chk_ld = chk_ld; v.e_ld = e_ld; v.e_berr = e_berr;
        vecs.push_back(v);
    endtask

    // Reference model: byte-level arithmetic on access size and address offset.
    function automatic int mdl_size(input logic [2:0] f3);
        return 1 << f3[1:0];
    endfunction

    function automatic logic mdl_fault(input logic ld, input logic st, input logic [2:0] f3, input logic [31:0] addr);
        if (!(ld || st)) return 1'b0;
        if (ld && (f3 == 3'd3 || f3 >= 3'd6)) return 1'b1;
        if (!ld && f3 >= 3'd3) return 1'b1;
        return (addr % mdl_size(f3)) != 0;
    endfunction

    function automatic logic [3:0] mdl_wstrb(input logic [2:0] f3, input logic [31:0] addr);
        int sz = mdl_size(f3);
        return 4'(((1 << sz) - 1) << (addr % 4));
    endfunction

    function automatic logic [31:0] mdl_wdata(input logic [2:0] f3, input logic [31:0] rs2);
        case (mdl_size(f3))
            1:       return (rs2 & 32'hFF) * 32'h0101_0101;
            2:       return (rs2 & 32'hFFFF) * 32'h0001_0001;
            default: return rs2;
        endcase
    endfunction

    function automatic logic [31:0] mdl_load(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] rdata);
        int sz = mdl_size(f3);
        logic [31:0] mask, v;
        mask = (sz == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * sz)) - 32'd1);
        v = (rdata >> (8 * (addr % 4))) & mask;
        if (f3 < 3'd4 && sz < 4 && (v & ((mask >> 1) + 32'd1)) != 0) v = v | ~mask;
        return v;
    endfunction

    // Starts one access from idle (start low beforehand), keeps start high through DONE and one extra cycle.
    task automatic run_access(input vec_t v, input string tag);
        int cyc;
        logic held_ok;
        i_load = v.ld; i_store = v.st; i_funct3 = v.f3; i_addr = v.addr; i_rs2_data = v.rs2;
        i_start = 1'b1;
        #1 chk({tag, " stall_idle"}, o_stall, v.ld | v.st);
        @(posedge clk); #1;
        if (!(v.ld || v.st) || v.e_fault) begin
            chk({tag, " skip_done"}, o_done, 1);
            chk({tag, " skip_misaligned"}, o_misaligned, v.e_fault);
            chk({tag, " skip_no_req"}, o_dmem_req, 0);
            chk({tag, " skip_stall"}, o_stall, 0);
        end else begin
            chk({tag, " req"}, o_dmem_req, 1);
            chk({tag, " we"}, o_dmem_we, v.st);
            chk({tag, " addr"}, o_dmem_addr, v.addr & 32'hFFFF_FFFC);
            chk({tag, " wstrb"}, o_dmem_wstrb, v.e_wstrb);
            if (v.st) chk({tag, " wdata"}, o_dmem_wdata, v.e_wdata);
            cyc = 0;
            held_ok = 1'b1;
            while (!o_done && cyc < 40) begin
                if (cyc == v.dly) begin
                    i_dmem_ack = 1'b1; i_dmem_rdata = v.rdata; i_dmem_err = v.err;
                end
                @(posedge clk); #1;
                i_dmem_ack = 1'b0; i_dmem_err = 1'b0; i_dmem_rdata = $urandom;
                cyc++;
                if (!o_done && (o_dmem_req !== 1'b1 || o_stall !== 1'b1)) held_ok = 1'b0;
            end
            chk({tag, " req_held"}, held_ok, 1);
            chk({tag, " done"}, o_done, 1);
            chk({tag, " done_latency"}, cyc, (v.dly >= TMO) ? TMO : v.dly + 1);
            chk({tag, " bus_err"}, o_bus_err, v.e_berr);
            chk({tag, " misaligned"}, o_misaligned, 0);
            chk({tag, " req_dropped"}, o_dmem_req, 0);
            chk({tag, " stall_done"}, o_stall, 0);
        end
        if (v.chk_ld) chk({tag, " load_data"}, o_load_data, v.e_ld);
        @(posedge clk); #1;
        chk({tag, " single_done"}, o_done, 0);
        i_start = 1'b0; i_load = 1'b0; i_store = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int dones;
        logic known;
        logic [31:0] exp_ld;

        rst_n = 1'b0; i_start = 0; i_load = 0; i_store = 0; i_funct3 = 0; i_addr = 0; i_rs2_data = 0;
        i_dmem_ack = 0; i_dmem_err = 0; i_dmem_rdata = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset stall", o_stall, 0);
        chk("reset done", o_done, 0);
        chk("reset req", o_dmem_req, 0);
        chk("reset wstrb", o_dmem_wstrb, 0);
        chk("reset load_data", o_load_data, 0);
        chk("reset flags", {o_misaligned, o_bus_err}, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        //       ld st f3    addr          rs2           dly rdata         err flt wstrb    wdata          cl e_ld          berr
        add_vec(0, 1, 3'd2, 32'h104,      32'hDEADBEEF, 2,  32'h0,        0,  0,  4'b1111, 32'hDEADBEEF, 0, 32'h0,        0);
        add_vec(1, 0, 3'd0, 32'h203,      32'h0,        0,  32'h80112233, 0,  0,  4'b0000, 32'h0,        1, 32'hFFFFFF80, 0);
        add_vec(1, 0, 3'd4, 32'h203,      32'h0,        0,  32'h80112233, 0,  0,  4'b0000, 32'h0,        1, 32'h00000080, 0);
        add_vec(0, 1, 3'd1, 32'h302,      32'h0000ABCD, 1,  32'h0,        0,  0,  4'b1100, 32'hABCDABCD, 0, 32'h0,        0);
        add_vec(1, 0, 3'd1, 32'h301,      32'h0,        0,  32'h0,        0,  1,  4'b0000, 32'h0,        0, 32'h0,        0);
        add_vec(1, 0, 3'd2, 32'h400,      32'h0,        3,  32'h12345678, 0,  0,  4'b0000, 32'h0,        1, 32'h12345678, 0);
        add_vec(1, 0, 3'd5, 32'h402,      32'h0,        0,  32'h80017FFF, 0,  0,  4'b0000, 32'h0,        1, 32'h00008001, 0);
        add_vec(1, 0, 3'd1, 32'h402,      32'h0,        1,  32'h80017FFF, 0,  0,  4'b0000, 32'h0,        1, 32'hFFFF8001, 0);
        add_vec(1, 0, 3'd1, 32'h400,      32'h0,        2,  32'h1234F00D, 0,  0,  4'b0000, 32'h0,        1, 32'hFFFFF00D, 0);
        add_vec(0, 0, 3'd2, 32'h777,      32'h0,        0,  32'h0,        0,  0,  4'b0000, 32'h0,        1, 32'hFFFFF00D, 0);
        add_vec(0, 1, 3'd0, 32'h501,      32'h123456A5, 0,  32'h0,        0,  0,  4'b0010, 32'hA5A5A5A5, 0, 32'h0,        0);
        add_vec(0, 1, 3'd2, 32'h502,      32'h0,        0,  32'h0,        0,  1,  4'b0000, 32'h0,        0, 32'h0,        0);
        add_vec(0, 1, 3'd4, 32'h500,      32'h0,        0,  32'h0,        0,  1,  4'b0000, 32'h0,        0, 32'h0,        0);
        add_vec(1, 0, 3'd3, 32'h500,      32'h0,        0,  32'h0,        0,  1,  4'b0000, 32'h0,        0, 32'h0,        0);
        add_vec(1, 0, 3'd6, 32'h500,      32'h0,        0,  32'h0,        0,  1,  4'b0000, 32'h0,        0, 32'h0,        0);
        add_vec(1, 0, 3'd2, 32'h600,      32'h0,        1,  32'h0,        1,  0,  4'b0000, 32'h0,        0, 32'h0,        1);
        add_vec(1, 0, 3'd0, 32'h100,      32'h0,        15, 32'h0000007F, 0,  0,  4'b0000, 32'h0,        1, 32'h0000007F, 0);
        add_vec(1, 0, 3'd2, 32'h700,      32'h0,        TMO, 32'h0,       0,  0,  4'b0000, 32'h0,        0, 32'h0,        1);
        add_vec(1, 0, 3'd4, 32'h101,      32'h0,        4,  32'h00009900, 0,  0,  4'b0000, 32'h0,        1, 32'h00000099, 0);

        foreach (vecs[i]) run_access(vecs[i], $sformatf("vec%0d", i));

        // Non-memory start held high for five cycles: exactly one done, re-arms after start drops.
        i_load = 0; i_store = 0; i_start = 1'b1; dones = 0;
        repeat (5) begin
            @(posedge clk); #1;
            dones += int'(o_done);
        end
        chk("held_start single_done", dones, 1);
        i_start = 1'b0;
        @(posedge clk); #1;
        chk("held_start low no_done", o_done, 0);
        i_start = 1'b1;
        @(posedge clk); #1;
        chk("held_start rearm_done", o_done, 1);
        i_start = 1'b0;
        @(posedge clk); #1;

        known = 1'b0;
        exp_ld = 32'h0;
        for (int n = 0; n < 80; n++) begin
            vec_t v;
            int kind;
            logic mem, timed_out;
            logic [2:0] ld_f3s [5];
            ld_f3s = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
            kind = $urandom_range(0, 9);
            v.ld = (kind < 5);
            v.st = (kind >= 5 && kind < 9);
            if ($urandom_range(0, 3) == 0) v.f3 = 3'($urandom_range(0, 7));
            else if (v.ld) v.f3 = ld_f3s[$urandom_range(0, 4)];
            else v.f3 = 3'($urandom_range(0, 2));
            v.addr = $urandom; v.rs2 = $urandom; v.rdata = $urandom;
            v.dly = ($urandom_range(0, 15) == 0) ? TMO : $urandom_range(0, 4);
            v.err = ($urandom_range(0, 7) == 0);
            v.e_fault = mdl_fault(v.ld, v.st, v.f3, v.addr);
            mem = (v.ld || v.st) && !v.e_fault;
            timed_out = mem && v.dly >= TMO;
            v.e_berr = mem && (timed_out || v.err);
            v.e_wstrb = (v.st && !v.ld) ? mdl_wstrb(v.f3, v.addr) : 4'b0000;
            v.e_wdata = mdl_wdata(v.f3, v.rs2);
            if (!(v.ld || v.st)) begin
                v.chk_ld = known; v.e_ld = exp_ld;
            end else if (v.ld && mem && !timed_out && !v.err) begin
                exp_ld = mdl_load(v.f3, v.addr, v.rdata);
                known = 1'b1; v.chk_ld = 1'b1; v.e_ld = exp_ld;
            end else begin
                known = 1'b0; v.chk_ld = 1'b0; v.e_ld = 32'h0;
            end
            run_access(v, $sformatf("rnd%0d", n));
        end

        // Async reset in the middle of a load: req drops at once, late ack is ignored, next access works.
        i_load = 1'b1; i_store = 1'b0; i_funct3 = 3'd2; i_addr = 32'h800; i_start = 1'b1;
        @(posedge clk); #1;
        chk("rst_mid req_up", o_dmem_req, 1);
        @(posedge clk); #2;
        i_start = 1'b0; i_load = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("rst_mid req_drop", o_dmem_req, 0);
        chk("rst_mid stall", o_stall, 0);
        chk("rst_mid load_data", o_load_data, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        i_dmem_ack = 1'b1; i_dmem_rdata = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        i_dmem_ack = 1'b0;
        chk("rst_mid late_ack no_done", o_done, 0);
        chk("rst_mid late_ack no_req", o_dmem_req, 0);
        chk("rst_mid late_ack load_data", o_load_data, 0);
        @(posedge clk); #1;
        vecs.delete();
        add_vec(1, 0, 3'd2, 32'h604, 32'h0, 1, 32'hCAFEF00D, 0, 0, 4'b0000, 32'h0, 1, 32'hCAFEF00D, 0);
        run_access(vecs[0], "after_rst");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
